// File: rtl/oled_pkg.sv
// Shared types for the OLED transaction path: payload limits, transaction
// record and the arbiter state encoding.
package oled_pkg;
  localparam int OLED_MAX_BYTES = 15;
  localparam int OLED_PAYLOAD_W = 120;
  localparam int OLED_COUNT_W   = $clog2(OLED_MAX_BYTES + 1);

  typedef struct packed {
    logic                      data_type;
    logic [OLED_COUNT_W-1:0]   byte_count;
    logic [OLED_PAYLOAD_W-1:0] bytes;
  } oled_txn_t;

  typedef enum logic [1:0] {IDLE, XFER, GAP} oled_arb_state_t;
endpackage

// File: rtl/oled_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping, reported as a one-hot vector and an index.
module oled_rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = IW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/oled_arbiter.sv
// Round-robin sequencer sharing the oled SPI transaction port among N_REQ
// requesters. Define OLED_ARB_TIMEOUT_EN to build the spi_done watchdog.
module oled_arbiter #(
  parameter int N_REQ          = 3,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   oled_ready,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_data_type,
  input  logic [4*N_REQ-1:0]     req_byte_count,
  input  logic [120*N_REQ-1:0]   req_bytes,
  output logic [N_REQ-1:0]       req_done,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   oled_data_type,
  output logic [3:0]             oled_byte_count,
  output logic [119:0]           oled_send_bytes,
  input  logic                   oled_spi_done,
  output logic                   timeout_err
);
  import oled_pkg::*;

  localparam int IW = $clog2(N_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  oled_arb_state_t   state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d, done_q, done_d;
  logic              busy_q, busy_d;
  oled_txn_t         txn_q, txn_d, win;
  logic [GW-1:0]     gap_q, gap_d;
  logic              to_hit;

  logic [N_REQ-1:0]  pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              arb_en;

  oled_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    win.data_type  = req_data_type[pick_idx];
    win.byte_count = req_byte_count[int'(pick_idx)*OLED_COUNT_W +: OLED_COUNT_W];
    win.bytes      = req_bytes[int'(pick_idx)*OLED_PAYLOAD_W +: OLED_PAYLOAD_W];
  end

  // The last GAP cycle doubles as an arbitration slot so the zero-count
  // window between payloads is exactly GAP_CYCLES long.
  assign arb_en = (state_q == IDLE) || (state_q == GAP && gap_q == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    done_d  = '0;
    txn_d   = txn_q;
    gap_d   = gap_q;
    case (state_q)
      XFER: begin
        if (!oled_ready) begin
          grant_d          = '0;
          txn_d.byte_count = '0;
          ptr_d            = (owner_q == '0) ? IW'(N_REQ - 1) : owner_q - 1'b1;
          state_d          = GAP;
          gap_d            = GAP_LOAD;
        end else if (oled_spi_done || to_hit) begin
          done_d           = grant_q;
          grant_d          = '0;
          txn_d.byte_count = '0;
          state_d          = GAP;
          gap_d            = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - 1'b1;
        else             state_d = IDLE;
      end
      default: ;
    endcase
    if (arb_en && oled_ready && pick_any) begin
      ptr_d = pick_idx;
      if (win.byte_count == '0) begin
        done_d  = pick_oh;
        state_d = GAP;
        gap_d   = GAP_LOAD;
      end else begin
        txn_d   = win;
        grant_d = pick_oh;
        owner_d = pick_idx;
        state_d = XFER;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      txn_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      txn_q   <= txn_d;
      gap_q   <= gap_d;
    end
  end

`ifdef OLED_ARB_TIMEOUT_EN
  logic [23:0] wdog_q, wdog_d;
  logic        terr_q, terr_d;

  always_comb begin
    wdog_d = (state_q == XFER) ? wdog_q + 24'd1 : '0;
    to_hit = (state_q == XFER) && (wdog_q == 24'(TIMEOUT_CYCLES - 1));
    terr_d = terr_q | (to_hit && oled_ready && !oled_spi_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      terr_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign grant           = grant_q;
  assign req_done        = done_q;
  assign busy            = busy_q;
  assign oled_data_type  = txn_q.data_type;
  assign oled_byte_count = txn_q.byte_count;
  assign oled_send_bytes = txn_q.bytes;
endmodule

// File: doc/oled_arbiter.md
# oled_arbiter

Round-robin arbiter and transaction sequencer that shares the `oled` block's single SPI transaction port among `N_REQ` independent requesters, e.g. a text renderer, a pixel/frame streamer and a contrast/scroll command source. It sits between the requesters and `oled`. It latches one transaction at a time, drives `oled`'s `data_type_in` / `byte_count_in` / `send_bytes_in`, waits for `spi_done`, and inserts an idle gap before the next grant so the SPI engine never sees back-to-back payloads.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters (2..8).
- `GAP_CYCLES`, 2: cycles with `oled_byte_count` = 0 between transactions (≥1).
- `TIMEOUT_CYCLES`, 1000000: watchdog limit on the wait for `spi_done`; used only with `OLED_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `oled_ready`  in  1  high when `oled` has finished startup (ACTIVE state).
- `req_valid`  in  N_REQ  per-requester request; held until that requester's `req_done`.
- `req_data_type`  in  N_REQ  0 = command, 1 = data.
- `req_byte_count`  in  4*N_REQ  bytes to send (0..15).
- `req_bytes`  in  120*N_REQ  payload, MSB-first bytes.
- `req_done`  out  N_REQ  one-cycle pulse when that requester's transaction completes.
- `grant`  out  N_REQ  one-hot owner of the OLED port; 0 when idle.
- `busy`  out  1  high in any state other than IDLE.
- `oled_data_type`  out  1  to `oled.data_type_in`.
- `oled_byte_count`  out  4  to `oled.byte_count_in`.
- `oled_send_bytes`  out  120  to `oled.send_bytes_in`.
- `oled_spi_done`  in  1  from `oled.spi_done`.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- All outputs are registered. Reset values: `grant` = 0, `req_done` = 0, `busy` = 0, `oled_data_type` = 0, `oled_byte_count` = 0, `oled_send_bytes` = 0, `timeout_err` = 0. The round-robin pointer resets so that requester 0 has the highest priority.
- The state machine has three states: IDLE, XFER and GAP.
- IDLE: if `oled_ready` is high and any `req_valid` is set, pick the first valid requester after the last-granted index, wrapping around.
  - Latch that requester's type, count and bytes into the `oled_*` outputs.
  - Set its `grant` bit, update the pointer, and go to XFER.
- IDLE, zero-length request: a winner with `req_byte_count` = 0 never reaches the OLED. `req_done` pulses on the next cycle, the pointer updates, and the state goes to GAP.
- XFER: outputs are held stable. On `oled_spi_done`:
  - pulse the owner's `req_done`;
  - clear `grant` and `oled_byte_count`;
  - go to GAP.
- GAP: hold `oled_byte_count` = 0 for `GAP_CYCLES` cycles, then return to IDLE.
- If `req_valid` drops during XFER, it is ignored: the transaction completes and `req_done` still pulses.
- If `oled_ready` falls during XFER, the transaction is aborted:
  - clear `grant` and `oled_byte_count`, go to GAP, and do not pulse `req_done`;
  - the requester stays pending and is re-arbitrated once `oled_ready` returns;
  - the pointer is restored so the same requester wins again.
- If `rst_n` asserts mid-transfer, all outputs clear immediately. Requesters must re-present their requests.
- Fairness: under saturation, no requester waits more than `N_REQ`−1 transactions.

## Timing
- Request sampled in IDLE at cycle t: `grant` and `oled_*` become valid at t+1.
- `oled_spi_done` seen at cycle d: `req_done` pulses and `oled_byte_count` = 0 at d+1. The next grant comes no earlier than d+1+`GAP_CYCLES`.
- Zero-length request: `req_done` at t+1, with no OLED activity.
- Requesters may change their payload after `grant`, because the arbiter has already latched it. The next payload may be presented the cycle after `req_done`.

## Configuration
- `OLED_ARB_TIMEOUT_EN` defined:
  - a 24-bit watchdog counts cycles in XFER;
  - on reaching `TIMEOUT_CYCLES` without `oled_spi_done`, it sets `timeout_err` (sticky until reset), pulses the owner's `req_done`, clears `oled_byte_count`, and goes to GAP.
- `OLED_ARB_TIMEOUT_EN` undefined: no counter is built, `timeout_err` is tied to 0, and XFER waits indefinitely.

## Structure
- Shared package `oled_pkg` holds:
  - `OLED_MAX_BYTES` = 15 and `OLED_PAYLOAD_W` = 120;
  - `oled_txn_t`, a packed struct of data_type, byte_count and bytes;
  - `oled_arb_state_t`, the enum IDLE/XFER/GAP.
- Sub-module `oled_rr_pick`: a combinational round-robin picker with inputs request vector + pointer and outputs one-hot winner + index.

## Test plan
- Single request, N_REQ = 3, req 1 with type 1, count 4, bytes 0xDEADBEEF, `oled_spi_done` 10 cycles after grant:
  - `grant` = 3'b010 one cycle after request;
  - `oled_byte_count` = 4;
  - `req_done[1]` pulses exactly once;
  - `oled_byte_count` = 0 for exactly 2 cycles.
- All three requesters valid continuously: grant order 0, 1, 2, 0, 1, 2. No grant occurs within `GAP_CYCLES` of the previous `req_done`.
- Req 2 with count 0: `req_done[2]` pulses one cycle after selection and `oled_byte_count` stays 0 throughout.
- `oled_ready` low with requests pending: no grant. `oled_ready` drops mid-XFER: abort with no `req_done`. When `oled_ready` rises again, the same requester is re-granted with an identical payload.
- `rst_n` pulsed low mid-XFER: all outputs are 0 immediately and asynchronously, and arbitration restarts at requester 0.
- With `OLED_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 50, no `oled_spi_done`: `timeout_err` = 1 and `req_done` pulses 50 cycles after grant. Without the macro, `timeout_err` stays 0 and `grant` is held.
